filter_decim_out: RTL and testbench
===================================

// Module: filter_decim_out
// PURPOSE
//  Downstream stage of the Q16.16 IIR filter. Consumes one 32-bit signed Q16.16 filter
//  sample per qualified clock and decimates by DECIM with a boxcar average.
//  Rounds each average to an integer, saturates it to OUT_W signed bits, and queues it
//  in a FIFO behind a valid/ready handshake for the consumer.
// PARAMETERS
//  DECIM       4   decimation ratio; power of two, 2..64
//  LOG2_DECIM  2   log2(DECIM); must match DECIM
//  OUT_W       16  output word width, signed, 2..32
//  FIFO_DEPTH  8   output FIFO entries; power of two, 2..64
// PORTS
//  clk        in   1           system clock, rising edge
//  rst        in   1           asynchronous, active-low reset
//  in         in   32          filter output sample, signed Q16.16
//  in_valid   in   1           qualifies in for this cycle
//  out_data   out  OUT_W       FIFO head word, signed integer
//  out_valid  out  1           FIFO non-empty
//  out_ready  in   1           consumer accepts head when out_valid & out_ready
//  overflow   out  1           sticky flag: a saturation has occurred
//  drop       out  1           one-cycle pulse: a result was discarded because the FIFO was full
// BEHAVIOUR
//  Reset (rst=0, async): acc, count, pipeline valids, FIFO pointers/occupancy cleared.
//   out_data=0, out_valid=0, overflow=0, drop=0. Any partial block is discarded.
//  Accumulate: on an edge with in_valid=1, acc += sext(in) (width 32+LOG2_DECIM+1).
//   count increments 0..DECIM-1. in_valid=0 leaves acc and count unchanged; gaps are allowed.
//  Dump (the edge where in_valid=1 and count==DECIM-1):
//   avg_r <= (acc + sext(in)) >>> LOG2_DECIM (arithmetic shift); avg_v <= 1.
//   acc <= 0; count <= 0.
//  Stage 2 (next edge):
//   r = (avg_r + 0x8000) >>> 16, i.e. round half toward +inf.
//   sat_r = clamp(r, -2^(OUT_W-1), 2^(OUT_W-1)-1); sat_v <= avg_v.
//   If clamping changed the value, overflow <= 1.
//   overflow stays set until reset.
//  Stage 3 (next edge): if sat_v, write sat_r to the FIFO.
//   The write is accepted when not full, or when full and a read occurs on the same edge.
//   Otherwise the word is dropped and drop=1 for exactly that cycle; FIFO contents are unchanged.
//  Latency: with an empty FIFO, a block's word is on out_data with out_valid=1 in the cycle
//   after the 3rd edge counting from its last-sample edge (edge E0 -> visible after E2).
//  FIFO: first-word-fall-through; out_data is the head; in-order delivery.
//   Read on an edge with out_valid & out_ready.
//   Simultaneous read and write: occupancy unchanged, both happen.
//   Reading with out_valid=0 is ignored.
//   Pointers wrap modulo FIFO_DEPTH; full = occupancy==FIFO_DEPTH.
//   out_data holds its last value when the FIFO is empty.
//  Throughput: at most one result per DECIM accepted samples; the pipeline never stalls the input.
// TESTING
//  1. DECIM=4; 4x in=0x0002_0000 with in_valid=1 -> out_data=0x0002, out_valid=1 after edge E0+2.
//  2. 4x 0x0001_8000 -> 0x0002; 4x 0xFFFE_8000 -> 0xFFFF. in_valid gaps between the samples do not change either result.
//  3. 4x 0x7FFF_FFFF -> 0x7FFF and overflow=1 (stays 1);
//     4x 0x8000_0000 -> 0x8000 with no new saturation.
//  4. out_ready=0; feed 9 blocks of distinct constants -> 8 words held, one drop pulse on the 9th.
//     Then out_ready=1 drains blocks 1..8 in order, one word per cycle.
//  5. FIFO full and out_ready=1 on the same edge as a write -> no drop; occupancy stays 8.
//  6. rst pulsed low after 2 of 4 samples -> outputs cleared immediately;
//     the next 4 samples of 0x0005_0000 -> exactly one word, 0x0005.

Source files
------------

// File: rtl/filter_decim_out.sv
// Boxcar decimator, rounder, saturator and output FIFO for Q16.16 IIR filter samples.
// Latency: 3 clk edges from a block's last sample to the FIFO head when the FIFO is empty.
// Backpressure: the input is never stalled; a word arriving at a full FIFO with no read that edge is dropped.
//
// Ports:
//   clk, rst       clock (rising edge) and asynchronous active-low reset
//   in, in_valid   signed Q16.16 sample and its qualifier
//   out_data       FIFO head word (holds its last value when the FIFO is empty)
//   out_valid      FIFO non-empty
//   out_ready      consumer takes the head when out_valid & out_ready
//   overflow       sticky: a rounded average was clamped to OUT_W bits
//   drop           one-cycle pulse: a result was discarded at a full FIFO

// First-word-fall-through FIFO with a held last-read word.
// Latency: a written word is at the head in the cycle after the write edge.
// Backpressure: a write at full is accepted only when a read occurs on the same edge; wr_acc reports it.
module filter_decim_out_fifo #(
    parameter int W     = 16,
    parameter int DEPTH = 8,
    parameter int AW    = 3
) (
    input  logic         clk,
    input  logic         rst,
    input  logic         wr_vld,
    input  logic [W-1:0] wr_dat,
    output logic         wr_acc,
    input  logic         rd_rdy,
    output logic         rd_vld,
    output logic [W-1:0] rd_dat
);
    logic [W-1:0]  mem [DEPTH];
    logic [AW-1:0] wr_ptr;
    logic [AW-1:0] rd_ptr;
    logic [AW:0]   occ;
    logic [W-1:0]  last_dat;
    logic          empty;
    logic          full;
    logic          rd_en;

    assign empty  = (occ == '0);
    assign full   = (occ == (AW+1)'(DEPTH));
    assign rd_en  = rd_rdy & ~empty;
    // A full FIFO can still take a word if the head leaves on the same edge.
    assign wr_acc = wr_vld & (~full | rd_en);
    assign rd_vld = ~empty;
    // Once drained, keep presenting the last word that left rather than a stale slot.
    assign rd_dat = empty ? last_dat : mem[rd_ptr];

    always_ff @(posedge clk) begin
        if (wr_acc) begin
            mem[wr_ptr] <= wr_dat;
        end
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            wr_ptr   <= '0;
            rd_ptr   <= '0;
            occ      <= '0;
            last_dat <= '0;
        end else begin
            if (wr_acc) begin
                wr_ptr <= wr_ptr + AW'(1);
            end
            if (rd_en) begin
                rd_ptr   <= rd_ptr + AW'(1);
                last_dat <= mem[rd_ptr];
            end
            case ({wr_acc, rd_en})
                2'b10:   occ <= occ + (AW+1)'(1);
                2'b01:   occ <= occ - (AW+1)'(1);
                default: occ <= occ;
            endcase
        end
    end
endmodule

module filter_decim_out #(
    parameter int DECIM      = 4,
    parameter int LOG2_DECIM = 2,
    parameter int OUT_W      = 16,
    parameter int FIFO_DEPTH = 8
) (
    input  logic             clk,
    input  logic             rst,
    input  logic [31:0]      in,
    input  logic             in_valid,
    output logic [OUT_W-1:0] out_data,
    output logic             out_valid,
    input  logic             out_ready,
    output logic             overflow,
    output logic             drop
);
    // One guard bit beyond the block growth keeps the rounding add from wrapping.
    localparam int ACC_W = 32 + LOG2_DECIM + 1;
    localparam int AW    = $clog2(FIFO_DEPTH);

    localparam logic signed [ACC_W-1:0] HALF    = ACC_W'(64'sd32768);
    localparam logic signed [ACC_W-1:0] SAT_MAX = ACC_W'((64'sd1 <<< (OUT_W-1)) - 64'sd1);
    localparam logic signed [ACC_W-1:0] SAT_MIN = ACC_W'(-(64'sd1 <<< (OUT_W-1)));

    logic signed [ACC_W-1:0] acc;
    logic [LOG2_DECIM-1:0]   count;
    logic signed [ACC_W-1:0] in_sext;
    logic signed [ACC_W-1:0] sum;
    logic                    dump;

    logic signed [ACC_W-1:0] avg_r;
    logic                    avg_v;
    logic signed [ACC_W-1:0] rnd_sum;
    logic signed [ACC_W-1:0] rnd;
    logic [OUT_W-1:0]        sat_val;
    logic                    clip;

    logic [OUT_W-1:0]        sat_r;
    logic                    sat_v;
    logic                    wr_acc;

    assign in_sext = {{(LOG2_DECIM+1){in[31]}}, in};
    assign sum     = acc + in_sext;
    assign dump    = in_valid && (count == LOG2_DECIM'(DECIM-1));

    // Stage 1: accumulate a block of DECIM samples, emit its average on the last one.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            acc   <= '0;
            count <= '0;
            avg_r <= '0;
            avg_v <= 1'b0;
        end else begin
            avg_v <= dump;
            if (dump) begin
                avg_r <= sum >>> LOG2_DECIM;
                acc   <= '0;
                count <= '0;
            end else if (in_valid) begin
                acc   <= sum;
                count <= count + LOG2_DECIM'(1);
            end
        end
    end

    // Stage 2: round half toward +inf to an integer, then clamp to OUT_W signed bits.
    assign rnd_sum = avg_r + HALF;
    assign rnd     = rnd_sum >>> 16;

    always_comb begin
        sat_val = rnd[OUT_W-1:0];
        clip    = 1'b0;
        if (rnd > SAT_MAX) begin
            sat_val = SAT_MAX[OUT_W-1:0];
            clip    = 1'b1;
        end else if (rnd < SAT_MIN) begin
            sat_val = SAT_MIN[OUT_W-1:0];
            clip    = 1'b1;
        end
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            sat_r    <= '0;
            sat_v    <= 1'b0;
            overflow <= 1'b0;
            drop     <= 1'b0;
        end else begin
            sat_v <= avg_v;
            if (avg_v) begin
                sat_r <= sat_val;
            end
            if (avg_v && clip) begin
                overflow <= 1'b1;
            end
            // Stage 3 outcome: the word offered this edge found no room.
            drop <= sat_v & ~wr_acc;
        end
    end

    filter_decim_out_fifo #(
        .W     (OUT_W),
        .DEPTH (FIFO_DEPTH),
        .AW    (AW)
    ) u_fifo (
        .clk    (clk),
        .rst    (rst),
        .wr_vld (sat_v),
        .wr_dat (sat_r),
        .wr_acc (wr_acc),
        .rd_rdy (out_ready),
        .rd_vld (out_valid),
        .rd_dat (out_data)
    );
endmodule

// File: tb/tb_filter_decim_out.sv
// Directed bench for filter_decim_out with DECIM=4, OUT_W=16, FIFO_DEPTH=8.
// Inputs change on the falling edge; outputs are sampled on the falling edge.
// Expected words are hand-computed block averages after rounding and clamping.
module tb_filter_decim_out;
    logic        clk = 1'b0;
    logic        rst = 1'b0;
    logic [31:0] din = '0;
    logic        in_valid = 1'b0;
    logic [15:0] out_data;
    logic        out_valid;
    logic        out_ready = 1'b0;
    logic        overflow;
    logic        drop;

    int errors = 0;
    int checks = 0;
    int drop_total = 0;

    always #5 clk = ~clk;

    filter_decim_out #(
        .DECIM      (4),
        .LOG2_DECIM (2),
        .OUT_W      (16),
        .FIFO_DEPTH (8)
    ) dut (
        .clk       (clk),
        .rst       (rst),
        .in        (din),
        .in_valid  (in_valid),
        .out_data  (out_data),
        .out_valid (out_valid),
        .out_ready (out_ready),
        .overflow  (overflow),
        .drop      (drop)
    );

    always @(negedge clk) begin
        if (drop) drop_total++;
    end

    // Four samples of v with 'gap' idle cycles between samples; returns on the
    // falling edge just after the block's last-sample edge.
    task automatic feed_block(input logic [31:0] v, input int gap);
        for (int i = 0; i < 4; i++) begin
            @(negedge clk);
            din      = v;
            in_valid = 1'b1;
            if (i < 3) begin
                for (int g = 0; g < gap; g++) begin
                    @(negedge clk);
                    in_valid = 1'b0;
                    din      = $urandom;
                end
            end
        end
        @(negedge clk);
        in_valid = 1'b0;
    endtask

    // Pop n words expected as first, first+1, ...; FIFO must be empty afterwards.
    task automatic drain(input int n, input logic [15:0] first);
        logic [15:0] exp;
        exp = first;
        out_ready = 1'b1;
        for (int i = 0; i < n; i++) begin
            checks++;
            if (out_valid !== 1'b1) begin
                errors++;
                $display("FAIL drain_valid[%0d]: got %b want 1", i, out_valid);
            end
            checks++;
            if (out_data !== exp) begin
                errors++;
                $display("FAIL drain_data[%0d]: got %h want %h", i, out_data, exp);
            end
            @(negedge clk);
            exp = exp + 16'd1;
        end
        out_ready = 1'b0;
        exp = exp - 16'd1;
        checks++;
        if (out_valid !== 1'b0) begin
            errors++;
            $display("FAIL drain_empty: out_valid got %b want 0", out_valid);
        end
        checks++;
        if (out_data !== exp) begin
            errors++;
            $display("FAIL drain_hold: out_data got %h want %h", out_data, exp);
        end
    endtask

    task automatic test_reset();
        rst = 1'b0;
        repeat (2) @(negedge clk);
        checks++;
        if ({out_valid, overflow, drop, out_data} !== 19'd0) begin
            errors++;
            $display("FAIL reset_outputs: got v=%b ov=%b dr=%b d=%h want all 0",
                     out_valid, overflow, drop, out_data);
        end
        rst = 1'b1;
        @(negedge clk);
    endtask

    task automatic test_latency();
        feed_block(32'h0002_0000, 0);
        checks++;
        if (out_valid !== 1'b0) begin
            errors++;
            $display("FAIL lat_e0: out_valid got %b want 0", out_valid);
        end
        @(negedge clk);
        checks++;
        if (out_valid !== 1'b0) begin
            errors++;
            $display("FAIL lat_e1: out_valid got %b want 0", out_valid);
        end
        @(negedge clk);
        checks++;
        if (out_valid !== 1'b1 || out_data !== 16'h0002) begin
            errors++;
            $display("FAIL lat_e2: got v=%b d=%h want v=1 d=0002", out_valid, out_data);
        end
        drain(1, 16'h0002);
    endtask

    task automatic test_rounding();
        for (int gap = 0; gap < 3; gap += 2) begin
            feed_block(32'h0001_8000, gap);
            repeat (2) @(negedge clk);
            drain(1, 16'h0002);
            feed_block(32'hFFFE_8000, gap);
            repeat (2) @(negedge clk);
            drain(1, 16'hFFFF);
        end
        checks++;
        if (overflow !== 1'b0) begin
            errors++;
            $display("FAIL round_no_ovf: overflow got %b want 0", overflow);
        end
    endtask

    task automatic test_saturation();
        feed_block(32'h7FFF_FFFF, 0);
        repeat (2) @(negedge clk);
        checks++;
        if (overflow !== 1'b1) begin
            errors++;
            $display("FAIL sat_ovf_set: overflow got %b want 1", overflow);
        end
        drain(1, 16'h7FFF);
        feed_block(32'h8000_0000, 0);
        repeat (2) @(negedge clk);
        drain(1, 16'h8000);
        checks++;
        if (overflow !== 1'b1) begin
            errors++;
            $display("FAIL sat_ovf_sticky: overflow got %b want 1", overflow);
        end
    endtask

    task automatic test_fifo_full_drop();
        int base;
        base = drop_total;
        out_ready = 1'b0;
        for (int k = 1; k <= 9; k++) begin
            feed_block({16'(k), 16'h0000}, 0);
        end
        repeat (4) @(negedge clk);
        checks++;
        if (drop_total - base !== 1) begin
            errors++;
            $display("FAIL full_drop_count: got %0d want 1", drop_total - base);
        end
        drain(8, 16'd1);
    endtask

    task automatic test_full_simul_rw();
        int base;
        base = drop_total;
        out_ready = 1'b0;
        for (int k = 11; k <= 18; k++) begin
            feed_block({16'(k), 16'h0000}, 0);
        end
        repeat (3) @(negedge clk);
        feed_block(32'h0013_0000, 0);
        @(negedge clk);
        // Read on exactly the edge that writes word 19 into the full FIFO.
        out_ready = 1'b1;
        @(negedge clk);
        out_ready = 1'b0;
        repeat (2) @(negedge clk);
        checks++;
        if (drop_total - base !== 0) begin
            errors++;
            $display("FAIL simul_rw_drop: got %0d want 0", drop_total - base);
        end
        drain(8, 16'd12);
    endtask

    task automatic test_async_reset();
        out_ready = 1'b0;
        feed_block(32'h0003_0000, 0);
        repeat (2) @(negedge clk);
        checks++;
        if (out_valid !== 1'b1 || out_data !== 16'h0003 || overflow !== 1'b1) begin
            errors++;
            $display("FAIL pre_reset_state: got v=%b d=%h ov=%b want v=1 d=0003 ov=1",
                     out_valid, out_data, overflow);
        end
        @(negedge clk);
        din      = 32'h0009_0000;
        in_valid = 1'b1;
        repeat (2) @(negedge clk);
        in_valid = 1'b0;
        #2 rst = 1'b0;
        #1;
        checks++;
        if ({out_valid, overflow, drop, out_data} !== 19'd0) begin
            errors++;
            $display("FAIL async_reset_clear: got v=%b ov=%b dr=%b d=%h want all 0",
                     out_valid, overflow, drop, out_data);
        end
        @(negedge clk);
        rst = 1'b1;
        feed_block(32'h0005_0000, 0);
        repeat (2) @(negedge clk);
        drain(1, 16'h0005);
        repeat (4) @(negedge clk);
        checks++;
        if (out_valid !== 1'b0) begin
            errors++;
            $display("FAIL post_reset_single: out_valid got %b want 0", out_valid);
        end
    endtask

    initial begin
        test_reset();
        test_latency();
        test_rounding();
        test_saturation();
        test_fifo_full_drop();
        test_full_simul_rw();
        test_async_reset();
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end
endmodule
